// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: state encoding and byte-to-word addressing constant
package mem_responder_pkg;

    localparam int WORD_OFF = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port word memory, synchronous write, registered read, no reset
module sp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // write port and read register share one address; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait states
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] word_idx;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rsp_data;
    logic              accept;
    logic              err;
    logic              ram_we;
    logic              ram_re;

    // request decode: acceptance, error classification, memory strobes, response data
    always_comb begin
        accept   = req_valid && (state_q == S_IDLE);
        word_idx = addr_q >> WORD_OFF;
        err      = (addr_q[WORD_OFF-1:0] != '0) || (word_idx >= DATA_W'(DEPTH));
        ram_we   = (state_q == S_ACCESS) && wr_q && !err;
        ram_re   = (state_q == S_ACCESS) && !wr_q && !err;
        rsp_data = (err || wr_q) ? '0 : ram_rdata;
    end

    // state register plus captured request and held response data
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // next state: wait counter runs WAIT_CYCLES cycles, then one ACCESS and one RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    cnt_d   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    // request fields only load on acceptance; response data latched while in RESP
    always_comb begin
        wr_d    = accept ? req_write : wr_q;
        addr_d  = accept ? req_addr  : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;
        rdata_d = (state_q == S_RESP) ? rsp_data : rdata_q;
    end

    // outputs decoded from state; rsp_rdata shows live data in RESP, held value elsewhere
    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_err   = (state_q == S_RESP) && err;
        rsp_rdata = (state_q == S_RESP) ? rsp_data : rdata_q;
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (word_idx[AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks on a 2-wait-state and a 0-wait-state responder
module tb_mem_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  v     = '0;
    logic [1:0]  w     = '0;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [1:0]  rdy, rv, er, bz;
    logic [31:0] rd [2];
    logic [31:0] last_rd [2];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulses;
    int          first;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .RESET_N(rst_n), .req_valid(v[0]), .req_write(w[0]),
        .req_addr(a[0]), .req_wdata(d[0]), .req_ready(rdy[0]), .rsp_valid(rv[0]),
        .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bz[0])
    );

    mem_responder #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .RESET_N(rst_n), .req_valid(v[1]), .req_write(w[1]),
        .req_addr(a[1]), .req_wdata(d[1]), .req_ready(rdy[1]), .rsp_valid(rv[1]),
        .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bz[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // s=0 -> WAIT_CYCLES=2 instance (response in cycle 4), s=1 -> WAIT_CYCLES=0 (cycle 2)
    task automatic xact(input int s, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_er, input string tag);
        int n;
        @(negedge clk);
        check({tag, ":idle_rv"}, 32'(rv[s]), 32'd0);
        check({tag, ":hold_rd"}, rd[s], last_rd[s]);
        check({tag, ":rdy"}, 32'(rdy[s]), 32'd1);
        v[s] = 1'b1; w[s] = wr; a[s] = addr; d[s] = wdata;
        @(posedge clk);
        #1;
        v[s] = 1'b0; w[s] = ~wr; a[s] = ~addr; d[s] = ~wdata;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rv[s]) break;
            check({tag, ":busy"}, {30'd0, bz[s], rdy[s]}, 32'd2);
        end
        check({tag, ":lat"}, 32'(n), (s == 0) ? 32'd4 : 32'd2);
        check({tag, ":rdata"}, rd[s], exp_rd);
        check({tag, ":err"}, 32'(er[s]), 32'(exp_er));
        last_rd[s] = exp_rd;
    endtask

    initial begin
        a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst:rdy", 32'(rdy[i]), 32'd1);
            check("rst:busy", 32'(bz[i]), 32'd0);
            check("rst:rv", 32'(rv[i]), 32'd0);
            check("rst:err", 32'(er[i]), 32'd0);
            check("rst:rdata", rd[i], 32'd0);
        end
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;

        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "w10");
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "r10");
        xact(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "r13_misalign");
        xact(0, 1'b1, 32'h0, 32'h0000CAFE, 32'h0, 1'b0, "w0");
        xact(0, 1'b1, 32'h100, 32'h11111111, 32'h0, 1'b1, "w100_range");
        xact(0, 1'b1, 32'h102, 32'h22222222, 32'h0, 1'b1, "w102_both");
        xact(0, 1'b0, 32'h0, 32'h0, 32'h0000CAFE, 1'b0, "r0_intact");
        xact(0, 1'b1, 32'hFC, 32'h600DF00D, 32'h0, 1'b0, "wFC_last");
        xact(0, 1'b0, 32'hFC, 32'h0, 32'h600DF00D, 1'b0, "rFC_last");
        xact(0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, "r100_range");

        xact(1, 1'b1, 32'h0, 32'h1, 32'h0, 1'b0, "z_w0");
        xact(1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0, "z_r0");
        xact(1, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, "z_r3_misalign");
        xact(1, 1'b1, 32'h4, 32'hA5A5A5A5, 32'h0, 1'b0, "z_w4");
        xact(1, 1'b0, 32'h4, 32'h0, 32'hA5A5A5A5, 1'b0, "z_r4");

        // req_valid held through the whole transaction, request fields changed after accept
        xact(0, 1'b1, 32'h24, 32'h1234, 32'h0, 1'b0, "w24_pre");
        @(negedge clk);
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 32'h20; d[0] = 32'hA5;
        @(posedge clk);
        #1;
        w[0] = 1'b0; a[0] = 32'h24; d[0] = 32'hBAD;
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (rv[0]) begin
                pulses++;
                if (first == 0) first = i;
                v[0] = 1'b0;
            end else if (i < 4) begin
                check("hold:rdy_busy", 32'(rdy[0]), 32'd0);
            end else begin
                check("hold:rdy_idle", 32'(rdy[0]), 32'd1);
            end
        end
        v[0] = 1'b0;
        check("hold:pulses", 32'(pulses), 32'd1);
        check("hold:lat", 32'(first), 32'd4);
        last_rd[0] = '0;
        xact(0, 1'b0, 32'h20, 32'h0, 32'hA5, 1'b0, "hold_r20");
        xact(0, 1'b0, 32'h24, 32'h0, 32'h1234, 1'b0, "hold_r24");

        // reset during WAIT of a write aborts it
        xact(0, 1'b1, 32'h8, 32'h77, 32'h0, 1'b0, "w8_pre");
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "r10_again");
        @(negedge clk);
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 32'h8; d[0] = 32'h55;
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        @(negedge clk);
        check("rst_wait:busy_before", 32'(bz[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_wait:busy", 32'(bz[0]), 32'd0);
        check("rst_wait:rv", 32'(rv[0]), 32'd0);
        check("rst_wait:rdy", 32'(rdy[0]), 32'd1);
        check("rst_wait:rdata", rd[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv[0]) pulses++;
        end
        check("rst_wait:no_rsp", 32'(pulses), 32'd0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        xact(0, 1'b0, 32'h8, 32'h0, 32'h77, 1'b0, "rst_r8");
        xact(1, 1'b0, 32'h4, 32'h0, 32'hA5A5A5A5, 1'b0, "z_r4_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 32: data and address width in bits.
REQ-002 Parameter DEPTH, default 64: number of DATA_W-bit words stored.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states inserted before each access, legal range 0..15.
REQ-004 clk  input  1: single clock, all state updates on rising edge.
REQ-005 RESET_N  input  1: reset, asynchronous, active-low.
REQ-006 req_valid  input  1: requester presents a memory request.
REQ-007 req_write  input  1: 1 = write, 0 = read.
REQ-008 req_addr  input  DATA_W: byte address.
REQ-009 req_wdata  input  DATA_W: write data.
REQ-010 req_ready  output  1: responder can accept a request this cycle.
REQ-011 rsp_valid  output  1: response strobe, one cycle wide.
REQ-012 rsp_rdata  output  DATA_W: read data, meaningful only while rsp_valid=1 for a read.
REQ-013 rsp_err  output  1: request was misaligned or out of range, meaningful only while rsp_valid=1.
REQ-014 busy  output  1: high in every state except IDLE.

Function
REQ-015 The block SHALL implement the FSM IDLE, WAIT, ACCESS, RESP, with a 4-bit wait counter.
REQ-016 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata SHALL be captured on that edge.
REQ-018 On acceptance, the FSM SHALL go to ACCESS if WAIT_CYCLES=0; otherwise it SHALL go to WAIT with the counter loaded with WAIT_CYCLES-1.
REQ-019 In WAIT: if the counter is 0, go to ACCESS; otherwise decrement the counter. WAIT therefore lasts exactly WAIT_CYCLES cycles.
REQ-020 ACCESS SHALL last one cycle, then go to RESP.
- Write with no error: the captured data is written to word req_addr[DATA_W-1:2].
- Read: the addressed word is registered into rsp_rdata.
REQ-021 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE; there is no response backpressure.
REQ-022 Latency: a request accepted in cycle 0 SHALL produce rsp_valid=1 in cycle WAIT_CYCLES+2.
REQ-023 Error condition: req_addr[1:0]!=0 or word index >= DEPTH.
- rsp_err=1 in RESP.
- No memory write occurs.
- rsp_rdata=0.
REQ-024 req_valid while not in IDLE SHALL be ignored, with no capture and no side effect.
REQ-025 A read accepted in the cycle immediately after a write's RESP SHALL return the newly written data.
REQ-026 A write response SHALL drive rsp_rdata=0.
REQ-027 Outside RESP, rsp_valid and rsp_err SHALL be 0, and rsp_rdata SHALL hold its last value.

Reset
REQ-028 While RESET_N=0 (asynchronously):
- state=IDLE, counter=0, captured request registers=0;
- rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, req_ready=1 once RESET_N=1.
REQ-029 Memory array contents SHALL NOT be reset.
REQ-030 Reset asserted in WAIT SHALL abort the pending write with no memory change and no response.
REQ-031 Reset asserted in ACCESS or RESP SHALL suppress any rsp_valid not yet issued.

Structure
REQ-032 Package mem_responder_pkg SHALL hold the state enumeration (2-bit encoding IDLE=0, WAIT=1, ACCESS=2, RESP=3) and the word-offset constant (2).
REQ-033 Storage SHALL be a sub-module sp_ram: single port, synchronous write, registered one-cycle read, no reset.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Write 0xDEADBEEF @0x10, then read @0x10 (WAIT_CYCLES=2) -> rsp_valid in cycle 4 after each accept; read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read @0x13 -> rsp_err=1, rsp_rdata=0. Write @0x100 with DEPTH=64 -> rsp_err=1, and word 0 is unchanged on readback.
- WAIT_CYCLES=0: back-to-back write 0x1 @0x0, then read @0x0 -> each response 2 cycles after accept; read returns 0x1.
- req_valid held high through a transaction -> exactly one response; req_ready=0 from accept through RESP; next accept only in IDLE.
- RESET_N low during WAIT of write 0x55 @0x8 -> no rsp_valid, busy=0; subsequent read @0x8 returns the prior value.
